sccb_init_sequencer: RTL and testbench
======================================

// Module: sccb_init_sequencer
// PURPOSE
//  Upstream driver for the SCCB/I2C master. Generates the SCCB bit clock and its
//  negative mid-cycle data pulse, and walks an external register-init table.
//  Each table entry is issued to the master as one 3-phase write.
//  Supports delay entries, per-entry retry on ACK error, and end-of-table detection.
//  Reports busy, done and error status to the camera-control logic.
// PARAMETERS
//  CLK_DIV     500    clk_i cycles per SCCB bit period; even, >= 8 (50 MHz -> 100 kHz)
//  MS_TICKS    50000  clk_i cycles per 1 ms, used by delay entries
//  DEV_ADDR    8'h42  device ID presented to the master; bit 0 is ignored by the master
//  TBL_AW      8      table address width
//  MAX_RETRY   3      retries per entry after the first attempt fails
// PORTS
//  clk_i        in   1      main clock
//  rst_i        in   1      asynchronous reset, active-high
//  go_i         in   1      1-cycle pulse; starts the sequence from entry 0
//  sccb_clk_o   out  1      SCCB bit clock to the master
//  data_pulse_o out  1      1-cycle pulse at the middle of the sccb_clk_o low phase
//  tbl_addr_o   out  TBL_AW table read address
//  tbl_data_i   in   16     {reg[15:8], val[7:0]}; read data valid 1 cycle after tbl_addr_o
//  dev_addr_o   out  8      device ID to the master; constant DEV_ADDR
//  data_o       out  16     {reg, val} to the master
//  rw_o         out  1      always 1 (write)
//  start_o      out  1      transaction request to the master
//  done_i       in   1      master transaction complete
//  ack_error_i  in   1      master ACK error; valid while done_i=1
//  busy_o       out  1      sequence in progress
//  done_o       out  1      sequence completed without error; sticky until go_i or reset
//  error_o      out  1      retries exhausted; sticky until go_i or reset
//  err_index_o  out  TBL_AW index of the failing entry, valid while error_o=1
// BEHAVIOUR
//  Reset values: all outputs 0 except sccb_clk_o=1 and rw_o=1; dev_addr_o=DEV_ADDR;
//   state=IDLE; divider counter cnt=0.
//  Divider: cnt counts 0..CLK_DIV-1 and wraps; it free-runs in every state.
//   sccb_clk_o = (cnt < CLK_DIV/2).
//   data_pulse_o = (cnt == 3*CLK_DIV/4), registered, exactly 1 clk_i cycle.
//  Entry decode:
//   reg=8'hFF -> end of table.
//   reg=8'hFE -> delay of val ms; val=0 means no delay.
//   any other reg -> write.
//  FSM states:
//   IDLE: go_i -> FETCH, with idx=0, retry=0, done_o=0, error_o=0.
//   FETCH: drive tbl_addr_o=idx for 1 cycle -> DECODE.
//   DECODE: latch tbl_data_i.
//    End -> DONE.
//    Delay -> DELAY, loading val*MS_TICKS into a counter.
//    Write -> XFER, with data_o=entry and start_o=1.
//   XFER: hold start_o and data_o stable until done_i=1, then start_o=0 next cycle.
//    ack_error_i=0 -> RELEASE with idx+1 and retry=0.
//    ack_error_i=1 and retry<MAX_RETRY -> RELEASE with retry+1 and the same idx.
//    otherwise -> ERROR, with err_index_o=idx.
//   RELEASE: wait for done_i=0 (master clears on its next data pulse) -> FETCH.
//   DELAY: count down to 0 -> FETCH with idx+1.
//   DONE: done_o=1 -> IDLE.
//   ERROR: error_o=1 -> IDLE.
//  busy_o=1 in every state except IDLE.
//  go_i while busy_o=1 is ignored.
//  idx reaching 2^TBL_AW-1 without an end marker: that entry is executed, then DONE
//   (no wrap-around).
//  start_o is never reasserted while done_i=1.
//  Reset mid-transfer: start_o drops immediately and the master aborts.
//  The divider phase is never disturbed by FSM activity.
// TESTING
//  Divider, CLK_DIV=8: sccb_clk_o high for cnt 0-3 and low for cnt 4-7;
//   data_pulse_o high only at cnt 6; period 8 cycles.
//  Table {0x1280, 0x1101, 0xFF00}, model ACKs all -> 2 writes with data_o=0x1280
//   then 0x1101; done_o=1, error_o=0.
//  Entry 0xFE02 with MS_TICKS=10 -> no start_o for 20 clk_i cycles, then the next
//   entry is fetched.
//  Entry 1 NACKs always, MAX_RETRY=3 -> 4 attempts at idx 1; error_o=1,
//   err_index_o=1, busy_o=0.
//  Entry 1 NACKs once, then ACKs -> 2 attempts, sequence completes with done_o=1.
//  rst_i pulsed during XFER -> start_o=0 and busy_o=0 asynchronously;
//   a subsequent go_i restarts at idx 0.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
// rtl/sccb_init_sequencer.sv - SCCB bit-clock generator and register-init table sequencer
//
// Purpose: free-running SCCB bit clock and mid-low data pulse, plus an FSM that walks
// an external init table and issues each write entry to the SCCB master.
// Ports:
//   clk_i, rst_i         main clock, asynchronous active-high reset
//   go_i                 start pulse (ignored while busy)
//   sccb_clk_o           SCCB bit clock
//   data_pulse_o         1-cycle pulse in the middle of the sccb_clk_o low phase
//   tbl_addr_o/tbl_data_i  table read port (data valid 1 cycle after address)
//   dev_addr_o, data_o, rw_o, start_o   transaction request to the master
//   done_i, ack_error_i  transaction completion / ACK status from the master
//   busy_o, done_o, error_o, err_index_o  sequence status
module sccb_init_sequencer #(
  parameter int         CLK_DIV   = 500,
  parameter int         MS_TICKS  = 50000,
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         TBL_AW    = 8,
  parameter int         MAX_RETRY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  output logic              sccb_clk_o,
  output logic              data_pulse_o,
  output logic [TBL_AW-1:0] tbl_addr_o,
  input  logic [15:0]       tbl_data_i,
  output logic [7:0]        dev_addr_o,
  output logic [15:0]       data_o,
  output logic              rw_o,
  output logic              start_o,
  input  logic              done_i,
  input  logic              ack_error_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [TBL_AW-1:0] err_index_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = $clog2(255 * MS_TICKS + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [CW-1:0]     CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]     CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0]     CNT_PULSE = CW'(3 * CLK_DIV / 4);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TBL_AW-1:0] IDX_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_XFER, S_RELEASE, S_DELAY, S_DONE, S_ERROR
  } state_t;

  // Divider: free-running, never touched by the FSM. Outputs are registered from
  // the next count so they line up exactly with the current cnt value.
  logic [CW-1:0] cnt, cnt_next;

  assign cnt_next = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt          <= '0;
      sccb_clk_o   <= 1'b1;
      data_pulse_o <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      sccb_clk_o   <= (cnt_next < CNT_HALF);
      data_pulse_o <= (cnt_next == CNT_PULSE);
    end
  end

  state_t            state, state_n;
  logic [TBL_AW-1:0] idx, idx_n;
  logic [RW-1:0]     retry, retry_n;
  logic [15:0]       data_q, data_n;
  logic              start_q, start_n;
  logic              done_q, done_n;
  logic              error_q, error_n;
  logic [TBL_AW-1:0] err_idx_q, err_idx_n;
  logic [DW-1:0]     dly_q, dly_n;
  // Set once the last table slot has been written; avoids wrapping idx to 0.
  logic              last_q, last_n;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      idx       <= '0;
      retry     <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      dly_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      retry     <= retry_n;
      data_q    <= data_n;
      start_q   <= start_n;
      done_q    <= done_n;
      error_q   <= error_n;
      err_idx_q <= err_idx_n;
      dly_q     <= dly_n;
      last_q    <= last_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    retry_n   = retry;
    data_n    = data_q;
    start_n   = start_q;
    done_n    = done_q;
    error_n   = error_q;
    err_idx_n = err_idx_q;
    dly_n     = dly_q;
    last_n    = last_q;
    case (state)
      S_IDLE: begin
        if (go_i) begin
          state_n = S_FETCH;
          idx_n   = '0;
          retry_n = '0;
          done_n  = 1'b0;
          error_n = 1'b0;
          last_n  = 1'b0;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (tbl_data_i[15:8] == 8'hFF) begin
          state_n = S_DONE;
        end else if (tbl_data_i[15:8] == 8'hFE) begin
          dly_n   = DW'(tbl_data_i[7:0]) * DW'(MS_TICKS);
          state_n = S_DELAY;
        end else if (!done_i) begin
          // Holding here while done_i is still high keeps start_o from being
          // raised before the master has cleared its previous completion.
          data_n  = tbl_data_i;
          start_n = 1'b1;
          state_n = S_XFER;
        end
      end
      S_XFER: begin
        if (done_i) begin
          start_n = 1'b0;
          if (!ack_error_i) begin
            retry_n = '0;
            if (idx == IDX_MAX) last_n = 1'b1;
            else                idx_n  = idx + TBL_AW'(1);
            state_n = S_RELEASE;
          end else if (retry < RETRY_MAX) begin
            retry_n = retry + RW'(1);
            state_n = S_RELEASE;
          end else begin
            err_idx_n = idx;
            state_n   = S_ERROR;
          end
        end
      end
      S_RELEASE: begin
        if (!done_i) state_n = last_q ? S_DONE : S_FETCH;
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          if (idx == IDX_MAX) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + TBL_AW'(1);
            state_n = S_FETCH;
          end
        end else begin
          dly_n = dly_q - DW'(1);
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      S_ERROR: begin
        error_n = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign tbl_addr_o  = idx;
  assign dev_addr_o  = DEV_ADDR;
  assign data_o      = data_q;
  assign rw_o        = 1'b1;
  assign start_o     = start_q;
  assign busy_o      = (state != S_IDLE);
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign err_index_o = err_idx_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb/tb_sccb_init_sequencer.sv - self-checking bench for sccb_init_sequencer
module tb_sccb_init_sequencer;

  localparam int TBL_AW = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              go_i = 1'b0;
  logic              sccb_clk_o, data_pulse_o;
  logic [TBL_AW-1:0] tbl_addr_o;
  logic [15:0]       tbl_data_i = 16'h0000;
  logic [7:0]        dev_addr_o;
  logic [15:0]       data_o;
  logic              rw_o, start_o;
  logic              done_i = 1'b0;
  logic              ack_error_i = 1'b0;
  logic              busy_o, done_o, error_o;
  logic [TBL_AW-1:0] err_index_o;

  sccb_init_sequencer #(
    .CLK_DIV(8), .MS_TICKS(10), .DEV_ADDR(8'h42), .TBL_AW(TBL_AW), .MAX_RETRY(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .go_i(go_i),
    .sccb_clk_o(sccb_clk_o), .data_pulse_o(data_pulse_o),
    .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data_i),
    .dev_addr_o(dev_addr_o), .data_o(data_o), .rw_o(rw_o), .start_o(start_o),
    .done_i(done_i), .ack_error_i(ack_error_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_index_o(err_index_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] mem [16];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  int          start_cyc_q [$];
  int          rel_q [$];
  logic [7:0]  nack_reg = 8'h00;
  int          nack_left = 0;

  initial forever begin
    @(posedge clk_i);
    cyc = cyc + 1;
  end

  // Table ROM: address is stable well before the negedge, data ready by DECODE.
  initial forever begin
    @(negedge clk_i);
    tbl_data_i = mem[tbl_addr_o];
  end

  // SCCB master model: records each request, answers after 3 cycles, holds done_i
  // until start_o drops, then clears it one cycle later.
  initial begin
    int n;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        done_i = 1'b0;
        ack_error_i = 1'b0;
      end else if (start_o && !done_i) begin
        obs_q.push_back(data_o);
        start_cyc_q.push_back(cyc);
        n = 0;
        while (!rst_i && n < 3) begin
          @(negedge clk_i);
          n++;
        end
        if (!rst_i) begin
          done_i = 1'b1;
          if (data_o[15:8] == nack_reg && nack_left > 0) begin
            ack_error_i = 1'b1;
            nack_left--;
          end
          n = 0;
          while (!rst_i && start_o && n < 100) begin
            @(negedge clk_i);
            n++;
          end
          @(negedge clk_i);
        end
        done_i = 1'b0;
        ack_error_i = 1'b0;
        rel_q.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_table();
    for (int i = 0; i < 16; i++) mem[i] = 16'hFF00;
    exp_q.delete();
    obs_q.delete();
    start_cyc_q.delete();
    rel_q.delete();
  endtask

  task automatic pulse_go();
    @(negedge clk_i);
    go_i = 1'b1;
    @(negedge clk_i);
    go_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    // let the master model finish its release handshake
    repeat (4) @(negedge clk_i);
    ok = !busy_o;
  endtask

  task automatic compare_writes(input string name);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d writes, expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [15:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_data: got %h expected %h", name, o, e);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_table();
    repeat (3) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0)     begin failures++; $display("FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (error_o !== 1'b0)    begin failures++; $display("FAIL reset_error: got %b expected 0", error_o); end
    checks++; if (start_o !== 1'b0)    begin failures++; $display("FAIL reset_start: got %b expected 0", start_o); end
    checks++; if (sccb_clk_o !== 1'b1) begin failures++; $display("FAIL reset_sccb_clk: got %b expected 1", sccb_clk_o); end
    checks++; if (data_pulse_o !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b expected 0", data_pulse_o); end
    checks++; if (rw_o !== 1'b1)       begin failures++; $display("FAIL reset_rw: got %b expected 1", rw_o); end
    checks++; if (dev_addr_o !== 8'h42) begin failures++; $display("FAIL reset_dev_addr: got %h expected 42", dev_addr_o); end
    checks++; if (data_o !== 16'h0)    begin failures++; $display("FAIL reset_data: got %h expected 0000", data_o); end
    checks++; if (tbl_addr_o !== 4'h0) begin failures++; $display("FAIL reset_tbl_addr: got %h expected 0", tbl_addr_o); end
    checks++; if (err_index_o !== 4'h0) begin failures++; $display("FAIL reset_err_index: got %h expected 0", err_index_o); end
    rst_i = 1'b0;
  endtask

  // Starts at the negedge reset was released, so divider count j%8 is known.
  task automatic test_divider();
    for (int j = 0; j < 24; j++) begin
      logic e_clk, e_pulse;
      e_clk = ((j % 8) < 4);
      e_pulse = ((j % 8) == 6);
      checks++;
      if (sccb_clk_o !== e_clk) begin
        failures++;
        $display("FAIL divider_clk[%0d]: got %b expected %b", j, sccb_clk_o, e_clk);
      end
      checks++;
      if (data_pulse_o !== e_pulse) begin
        failures++;
        $display("FAIL divider_pulse[%0d]: got %b expected %b", j, data_pulse_o, e_pulse);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_writes();
    bit ok;
    clear_table();
    mem[0] = 16'h1280; mem[1] = 16'h1101; mem[2] = 16'hFF00;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
    pulse_go();
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL writes_busy: got %b expected 1", busy_o); end
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL writes_timeout: busy_o still %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL writes_done: got %b expected 1", done_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL writes_error: got %b expected 0", error_o); end
    compare_writes("writes");
  endtask

  task automatic test_delay();
    bit ok;
    int gap;
    clear_table();
    mem[0] = 16'h1280; mem[1] = 16'hFE02; mem[2] = 16'h1101; mem[3] = 16'hFF00;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
    pulse_go();
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL delay_timeout: busy_o still %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL delay_done: got %b expected 1", done_o); end
    gap = (start_cyc_q.size() > 1 && rel_q.size() > 0) ? start_cyc_q[1] - rel_q[0] : -1;
    checks++;
    if (gap < 20 || gap > 40) begin
      failures++;
      $display("FAIL delay_gap: got %0d cycles without start, expected 20..40", gap);
    end
    compare_writes("delay");
  endtask

  task automatic test_nack_always();
    bit ok;
    clear_table();
    mem[0] = 16'h1280; mem[1] = 16'h1101; mem[2] = 16'hFF00;
    nack_reg = 8'h11;
    nack_left = 99;
    exp_q.push_back(16'h1280);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h1101);
    pulse_go();
    wait_idle(2000, ok);
    nack_left = 0;
    checks++; if (!ok) begin failures++; $display("FAIL nack_timeout: busy_o still %b expected 0", busy_o); end
    checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL nack_error: got %b expected 1", error_o); end
    checks++; if (err_index_o !== 4'd1) begin failures++; $display("FAIL nack_err_index: got %0d expected 1", err_index_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL nack_done: got %b expected 0", done_o); end
    compare_writes("nack_always");
  endtask

  task automatic test_nack_once();
    bit ok;
    clear_table();
    mem[0] = 16'h1280; mem[1] = 16'h1101; mem[2] = 16'hFF00;
    nack_reg = 8'h11;
    nack_left = 1;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101); exp_q.push_back(16'h1101);
    pulse_go();
    wait_idle(2000, ok);
    nack_left = 0;
    checks++; if (!ok) begin failures++; $display("FAIL retry_timeout: busy_o still %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL retry_done: got %b expected 1", done_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL retry_error: got %b expected 0", error_o); end
    compare_writes("nack_once");
  endtask

  task automatic test_reset_mid_xfer();
    bit ok;
    int n = 0;
    clear_table();
    mem[0] = 16'h1280; mem[1] = 16'h1101; mem[2] = 16'hFF00;
    pulse_go();
    while (!start_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checks++; if (start_o !== 1'b1) begin failures++; $display("FAIL rstx_start_seen: got %b expected 1", start_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (start_o !== 1'b0) begin failures++; $display("FAIL rstx_start_async: got %b expected 0", start_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstx_busy_async: got %b expected 0", busy_o); end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    clear_table();
    mem[0] = 16'h1280; mem[1] = 16'h1101; mem[2] = 16'hFF00;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
    pulse_go();
    wait_idle(2000, ok);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL rstx_done: got %b expected 1", done_o); end
    compare_writes("reset_restart");
  endtask

  task automatic test_back_to_back_full_table();
    bit ok;
    clear_table();
    for (int i = 0; i < 16; i++) begin
      mem[i] = {8'(8'h20 + i), 8'(i)};
      exp_q.push_back(mem[i]);
    end
    pulse_go();
    repeat (30) @(negedge clk_i);
    go_i = 1'b1;
    @(negedge clk_i);
    go_i = 1'b0;
    wait_idle(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout: busy_o still %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL full_done: got %b expected 1", done_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL full_error: got %b expected 0", error_o); end
    compare_writes("full_table");
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_divider();
    test_writes();
    test_delay();
    test_nack_always();
    test_nack_once();
    test_reset_mid_xfer();
    test_back_to_back_full_table();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
